// File: rtl/fighter_anim_pkg.sv
// Shared encodings and the constant animation table
// used by the fighter animation sequencer.
package fighter_anim_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WALK = 4'd1,
    ST_JUMP = 4'd2,
    ST_ATK1 = 4'd3,
    ST_ATK2 = 4'd4,
    ST_HIT  = 4'd5
  } anim_state_e;

  typedef enum logic [1:0] {
    M_LOOP    = 2'd0,
    M_HOLD    = 2'd1,
    M_ONESHOT = 2'd2
  } anim_mode_e;

  typedef struct packed {
    logic [11:0] base;
    logic [7:0]  frames;
    logic [7:0]  hold;
    anim_mode_e  mode;
  } anim_row_t;

  // Unlisted state codes fall back to the idle row.
  function automatic anim_row_t anim_lookup(
    input logic [31:0] st
  );
    anim_row_t r;
    r = '{12'h000, 8'd4, 8'd8, M_LOOP};
    case (st)
      32'(ST_WALK): r = '{12'h010, 8'd6, 8'd4, M_LOOP};
      32'(ST_JUMP): r = '{12'h020, 8'd1, 8'd1, M_HOLD};
      32'(ST_ATK1): r = '{12'h030, 8'd5, 8'd3, M_ONESHOT};
      32'(ST_ATK2): r = '{12'h040, 8'd7, 8'd3, M_ONESHOT};
      32'(ST_HIT):  r = '{12'h050, 8'd1, 8'd1, M_HOLD};
      default:      r = '{12'h000, 8'd4, 8'd8, M_LOOP};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/anim_channel.sv
// One fighter's animation timing: hold counter, frame
// index, one-shot tracking and the registered sprite id.
module anim_channel
  import fighter_anim_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int FRAME_W = 6,
  parameter int ID_W    = 12,
  parameter int HOLD_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic [STATE_W-1:0] state_i,
  output logic [ID_W-1:0]    sprite_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               done_o,
  output logic               busy_o
);

  logic [STATE_W-1:0] cur_q, cur_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [ID_W-1:0]    sprite_q, sprite_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               chg;
  logic [STATE_W-1:0] sel;
  anim_row_t          row;
  logic [FRAME_W-1:0] last_frame;
  logic [HOLD_W-1:0]  hold_last;
  logic               spent;

  // One table lookup serves both the new state on a
  // change and the current state otherwise.
  always_comb begin
    chg        = (state_i != cur_q);
    sel        = chg ? state_i : cur_q;
    row        = anim_lookup(32'(sel));
    last_frame = FRAME_W'(row.frames - 8'd1);
    hold_last  = HOLD_W'(row.hold - 8'd1);
    spent      = (row.mode == M_ONESHOT) && !busy_q;
  end

  // Next-state: a state change beats a same-cycle tick.
  always_comb begin
    cur_d   = cur_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (chg) begin
      cur_d   = state_i;
      frame_d = '0;
      hold_d  = '0;
      busy_d  = (row.mode == M_ONESHOT);
    end else if (tick_i && !spent) begin
      if (hold_q < hold_last) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = '0;
        unique case (row.mode)
          M_LOOP: begin
            if (frame_q == last_frame)
              frame_d = '0;
            else
              frame_d = frame_q + FRAME_W'(1);
          end
          M_ONESHOT: begin
            if (frame_q < last_frame) begin
              frame_d = frame_q + FRAME_W'(1);
            end else begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end
          end
          default: frame_d = frame_q;
        endcase
      end
    end
  end

  // Sprite follows the state and frame of the same edge.
  always_comb begin
    sprite_d = ID_W'(row.base) + ID_W'(frame_d);
  end

  // Channel registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= '0;
      frame_q  <= '0;
      hold_q   <= '0;
      sprite_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
      sprite_q <= sprite_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sprite_o = sprite_q;
  assign frame_o  = frame_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;

endmodule

// File: rtl/anim_sequencer.sv
// Multi-channel animation sequencer: one independent
// anim_channel per fighter, ports flattened.
module anim_sequencer
  import fighter_anim_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int STATE_W = 4,
  parameter int FRAME_W = 6,
  parameter int ID_W    = 12,
  parameter int HOLD_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic [N_CH*STATE_W-1:0] anim_state,
  output logic [N_CH*ID_W-1:0]    sprite_id,
  output logic [N_CH*FRAME_W-1:0] anim_frame,
  output logic [N_CH-1:0]         anim_done,
  output logic [N_CH-1:0]         anim_busy
);

  // Channels share only the clock, reset and tick.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    anim_channel #(
      .STATE_W (STATE_W),
      .FRAME_W (FRAME_W),
      .ID_W    (ID_W),
      .HOLD_W  (HOLD_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (frame_tick),
      .state_i  (anim_state[k*STATE_W +: STATE_W]),
      .sprite_o (sprite_id[k*ID_W +: ID_W]),
      .frame_o  (anim_frame[k*FRAME_W +: FRAME_W]),
      .done_o   (anim_done[k]),
      .busy_o   (anim_busy[k])
    );
  end

endmodule
